// File: rtl/mdr_load_ctrl.sv
// Memory data register load controller: issues one word read per request,
// aligns the addressed byte/halfword into the low bits, and flags misalignment or bus timeout.
module mdr_load_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  loadSel,
  output logic [31:0] memAddr,
  output logic        memRead,
  input  logic        memReady,
  input  logic [31:0] memDataIn,
  output logic [31:0] mdrOut,
  output logic [1:0]  exceptionControl,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [1:0]    offset_q, offset_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] mem_addr_d;
  logic          mem_read_d;
  logic [DW-1:0] mdr_d;
  logic [1:0]    exc_d;
  logic          busy_d;
  logic          done_d;

  logic          misaligned_c;
  logic          timeout_hit_c;
  logic [DW-1:0] shifted_c;
  logic [DW-1:0] aligned_c;

  // Request classification and read-data lane alignment
  always_comb begin
    misaligned_c  = ((loadSel == 2'b01) && addr[0]) ||
                    (loadSel[1] && (addr[1:0] != 2'b00));
    timeout_hit_c = (cnt_q == CW'(TIMEOUT - 1));
    shifted_c     = memDataIn >> {offset_q, 3'b000};
    case (sel_q)
      2'b00:   aligned_c = {24'h000000, shifted_c[7:0]};
      2'b01:   aligned_c = {16'h0000, shifted_c[15:0]};
      default: aligned_c = memDataIn;
    endcase
  end

  // State register plus the registered outputs and request context
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q          <= S_IDLE;
      offset_q         <= 2'b00;
      sel_q            <= 2'b00;
      cnt_q            <= '0;
      memAddr          <= '0;
      memRead          <= 1'b0;
      mdrOut           <= '0;
      exceptionControl <= EXC_NONE;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_d;
      offset_q         <= offset_d;
      sel_q            <= sel_d;
      cnt_q            <= cnt_d;
      memAddr          <= mem_addr_d;
      memRead          <= mem_read_d;
      mdrOut           <= mdr_d;
      exceptionControl <= exc_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !misaligned_c) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (memReady || timeout_hit_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; memReady wins over timeout
  always_comb begin
    offset_d   = offset_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    mem_addr_d = memAddr;
    mem_read_d = memRead;
    mdr_d      = mdrOut;
    exc_d      = exceptionControl;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exc_d = EXC_NONE;
          if (misaligned_c) begin
            exc_d  = EXC_MISALIGN;
            done_d = 1'b1;
          end else begin
            mem_addr_d = {addr[31:2], 2'b00};
            mem_read_d = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = '0;
            offset_d   = addr[1:0];
            sel_d      = loadSel;
          end
        end
      end
      S_WAIT: begin
        if (memReady) begin
          mdr_d      = aligned_c;
          mem_read_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (timeout_hit_c) begin
            exc_d      = EXC_TIMEOUT;
            mem_read_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: begin
        mem_read_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mdr_load_ctrl.sv
// Directed bench for mdr_load_ctrl: byte/half/word loads, misalignment,
// timeout, ready-vs-timeout priority, start-in-WAIT and mid-access reset.
module tb_mdr_load_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [31:0] addr;
  logic [1:0]  loadSel;
  logic [31:0] memAddr;
  logic        memRead;
  logic        memReady;
  logic [31:0] memDataIn;
  logic [31:0] mdrOut;
  logic [1:0]  exceptionControl;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;
  int busy_cnt;

  mdr_load_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .resetN(resetN), .start(start), .addr(addr), .loadSel(loadSel),
    .memAddr(memAddr), .memRead(memRead), .memReady(memReady), .memDataIn(memDataIn),
    .mdrOut(mdrOut), .exceptionControl(exceptionControl), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".memAddr"}, memAddr, 32'h0);
    chk({tag, ".memRead"}, 32'(memRead), 32'h0);
    chk({tag, ".mdrOut"}, mdrOut, 32'h0);
    chk({tag, ".exc"}, 32'(exceptionControl), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; addr = '0; loadSel = 2'b00;
    memReady = 1'b0; memDataIn = '0;
    tick(); tick();
    chk_zero_outputs("reset");
    resetN = 1'b1;

    // Byte load, ready on first WAIT cycle
    start = 1'b1; addr = 32'h0000_0103; loadSel = 2'b00;
    tick();
    start = 1'b0;
    chk("byte.memAddr", memAddr, 32'h0000_0100);
    chk("byte.memRead", 32'(memRead), 32'h1);
    chk("byte.busy", 32'(busy), 32'h1);
    chk("byte.done_early", 32'(done), 32'h0);
    memReady = 1'b1; memDataIn = 32'hAABB_CCDD;
    tick();
    memReady = 1'b0;
    chk("byte.done", 32'(done), 32'h1);
    chk("byte.mdrOut", mdrOut, 32'h0000_00AA);
    chk("byte.memRead_off", 32'(memRead), 32'h0);
    chk("byte.exc", 32'(exceptionControl), 32'h0);
    tick();
    chk("byte.done_pulse", 32'(done), 32'h0);
    chk("byte.memAddr_hold", memAddr, 32'h0000_0100);

    // Halfword load, ready after 3 WAIT cycles
    start = 1'b1; addr = 32'h0000_0012; loadSel = 2'b01;
    tick();
    start = 1'b0; memDataIn = 32'h1234_5678;
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) busy_cnt++;
      chk("half.no_done", 32'(done), 32'h0);
      tick();
    end
    if (busy) busy_cnt++;
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("half.busy_cycles", 32'(busy_cnt), 32'd4);
    chk("half.done", 32'(done), 32'h1);
    chk("half.mdrOut", mdrOut, 32'h0000_1234);
    chk("half.busy_off", 32'(busy), 32'h0);
    tick();
    chk("half.done_pulse", 32'(done), 32'h0);

    // Misaligned word
    start = 1'b1; addr = 32'h0000_0006; loadSel = 2'b10;
    tick();
    start = 1'b0;
    chk("mis.exc", 32'(exceptionControl), 32'h1);
    chk("mis.done", 32'(done), 32'h1);
    chk("mis.memRead", 32'(memRead), 32'h0);
    chk("mis.mdrOut", mdrOut, 32'h0000_1234);
    tick();
    chk("mis.done_pulse", 32'(done), 32'h0);
    chk("mis.exc_sticky", 32'(exceptionControl), 32'h1);
    chk("mis.memRead_idle", 32'(memRead), 32'h0);

    // Timeout with memReady held low
    start = 1'b1; addr = 32'h0000_0020; loadSel = 2'b10;
    tick();
    start = 1'b0;
    chk("tmo.exc_cleared", 32'(exceptionControl), 32'h0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_cnt++;
      tick();
    end
    chk("tmo.wait_cycles", 32'(busy_cnt), 32'd16);
    chk("tmo.exc", 32'(exceptionControl), 32'h2);
    chk("tmo.done", 32'(done), 32'h1);
    chk("tmo.memRead", 32'(memRead), 32'h0);
    chk("tmo.mdrOut", mdrOut, 32'h0000_1234);

    // Next accepted start clears the exception; ready on the 16th WAIT cycle wins
    start = 1'b1; addr = 32'h0000_0040; loadSel = 2'b11;
    tick();
    start = 1'b0;
    chk("pri.exc_cleared", 32'(exceptionControl), 32'h0);
    chk("pri.memRead", 32'(memRead), 32'h1);
    for (int i = 0; i < 15; i++) tick();
    chk("pri.still_busy", 32'(busy), 32'h1);
    memReady = 1'b1; memDataIn = 32'hCAFE_F00D;
    tick();
    memReady = 1'b0;
    chk("pri.done", 32'(done), 32'h1);
    chk("pri.exc", 32'(exceptionControl), 32'h0);
    chk("pri.mdrOut", mdrOut, 32'hCAFE_F00D);

    // start during WAIT is ignored
    start = 1'b1; addr = 32'h0000_0080; loadSel = 2'b10;
    tick();
    addr = 32'h0000_0084;
    tick();
    start = 1'b0;
    chk("ign.memAddr", memAddr, 32'h0000_0080);
    chk("ign.busy", 32'(busy), 32'h1);
    memReady = 1'b1; memDataIn = 32'h0102_0304;
    tick();
    memReady = 1'b0;
    chk("ign.done", 32'(done), 32'h1);
    chk("ign.mdrOut", mdrOut, 32'h0102_0304);
    tick();
    chk("ign.no_second_read", 32'(memRead), 32'h0);
    chk("ign.memAddr_hold", memAddr, 32'h0000_0080);

    // Reset during WAIT abandons the access
    start = 1'b1; addr = 32'h0000_0200; loadSel = 2'b00;
    tick();
    start = 1'b0;
    chk("rst.memRead", 32'(memRead), 32'h1);
    resetN = 1'b0;
    tick();
    chk_zero_outputs("rst_mid");
    resetN = 1'b1; memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("rst.no_done", 32'(done), 32'h0);
    chk("rst.idle_read", 32'(memRead), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mdr_load_ctrl.md
Name: mdr_load_ctrl

Overview:
- Upstream neighbour of the load-size stage. Runs one memory read per request, aligns the addressed byte or halfword into the low bits, and holds the result in the memory data register (mdrOut).
- Detects misaligned loads and bus timeouts and reports them on exceptionControl.
- mdrOut and exceptionControl drive the load-size stage directly. loadSel is shared with that stage.

Parameters:
- TIMEOUT, 16, number of WAIT cycles without memReady before a bus-timeout exception. Legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- resetN  in  1  synchronous reset, active-low
- start  in  1  request strobe, sampled only in IDLE
- addr  in  32  byte address of the load
- loadSel  in  2  access size: 00 byte, 01 halfword, 10/11 word
- memAddr  out  32  word-aligned address to memory
- memRead  out  1  read request, held high until completion or timeout
- memReady  in  1  memory data valid this cycle
- memDataIn  in  32  memory read data, little-endian lanes (byte 0 = bits 7:0)
- mdrOut  out  32  aligned load data (MDR)
- exceptionControl  out  2  00 none, 01 misaligned, 10 bus timeout, 11 never driven
- busy  out  1  high while in WAIT
- done  out  1  one-cycle completion pulse, success or exception

Behaviour:
- Reset: one clock is the only clock, and reset is synchronous and active-low. Reset is sampled on the rising edge of clk with resetN=0. It forces state=IDLE, memAddr=0, memRead=0, mdrOut=0, exceptionControl=00, busy=0, done=0, and wait counter=0. Reset mid-WAIT abandons the access; no done pulse is produced.
- All outputs are registered.
- done defaults to 0 every cycle unless set below.
- States: IDLE, WAIT.
- IDLE with start=1 (request accepted):
  - exceptionControl is cleared to 00 at accept.
  - Misaligned request: loadSel=01 with addr[0]=1, or loadSel=1x with addr[1:0]!=00. Next cycle: exceptionControl=01, done=1, memRead stays 0, mdrOut unchanged, state stays IDLE. Latency 1 cycle.
  - Aligned request: next cycle memAddr={addr[31:2],2'b00}, memRead=1, busy=1, counter=0. Register byte offset addr[1:0] and loadSel internally. Go to WAIT.
- IDLE with start=0: hold all registers.
- WAIT, memReady=1: mdrOut = memDataIn >> (8*offset), zero-filled from the top. Effective lanes:
  - byte: lane offset in bits 7:0
  - half: bits 15:0 from offset 0 or 2
  - word: unshifted
  - Same edge: memRead=0, busy=0, done=1, state to IDLE, exceptionControl stays 00.
  - Minimum latency: start sampled at edge E0, memReady sampled at E1, done and mdrOut valid after E1 (2 cycles).
- WAIT, memReady=0: counter increments.
  - When counter==TIMEOUT-1 on that edge: exceptionControl=10, done=1, memRead=0, busy=0, mdrOut unchanged, state to IDLE.
  - memReady=1 on the would-be timeout edge counts as success; memReady has priority.
- start in WAIT is ignored; no queueing.
- start in the same cycle done is high is accepted, since the state is already IDLE. Back-to-back requests therefore yield 1 idle-gap-free sequence.
- memAddr holds its last value after completion.
- exceptionControl is sticky until the next accepted start or reset.
- mdrOut changes only on successful completion or reset.
- Counter width is 8 bits. No wrap is possible because timeout fires first.

Test Plan:
- Reset then byte load: addr=0x00000103, loadSel=00, memDataIn=0xAABBCCDD, memReady on the first WAIT cycle -> memAddr=0x00000100, memRead high 1 cycle, mdrOut=0x000000AA, done pulse 2 cycles after start, exceptionControl=00.
- Half load addr=0x00000012, loadSel=01, memDataIn=0x12345678, memReady after 3 WAIT cycles -> mdrOut=0x00001234, busy high 4 cycles, single done pulse.
- Misaligned word addr=0x00000006, loadSel=10 -> next cycle exceptionControl=01, done=1, memRead never high, mdrOut keeps previous 0x00001234.
- Timeout with TIMEOUT=16, memReady held 0 -> exactly 16 WAIT cycles, then exceptionControl=10 and done=1, memRead drops. A subsequent accepted start clears exceptionControl to 00.
- Priority and reset: memReady=1 on the 16th WAIT cycle -> success, exceptionControl=00. Separately, resetN=0 during WAIT -> next cycle all outputs zero, no done. start pulses during WAIT are ignored, with no second memRead.
